mem_access: RTL and testbench
=============================

# mem_access

Pipeline stage that consumes the execute-stage bundle (lock, opcode, scalar/vector ALU results, destination index/value, stall flags) and performs data-memory access. LDW and STW go to an external variable-latency data memory over a req/ack handshake. All other opcodes pass through to writeback in one edge. While a memory access is outstanding, the stage freezes the upstream pipeline. A watchdog aborts accesses the memory never acknowledges.

## Interface
- REG_W, 16: scalar register / memory data width.
- VREG_W, 64: vector register width (4 x 16-bit lanes).
- OPC_W, 8: opcode width; LDW/STW encodings are the `OP_LDW`/`OP_STW` values from global_def.h.
- TIMEOUT, 15: edges in WAIT without ack before abort (1..255).
- I_CLOCK  in  1  pipeline clock; all state updates on falling edge.
- I_RESET_N  in  1  asynchronous, active-low reset.
- I_LOCK  in  1  upstream lock (pipeline running).
- I_Opcode  in  OPC_W  opcode from execute.
- I_ALUOut  in  REG_W  scalar result; effective address for LDW/STW.
- I_VALUOut  in  VREG_W  vector result.
- I_DestRegIdx  in  4  destination register index.
- I_DestValue  in  REG_W  store data for STW.
- I_FetchStall, I_DepStall  in  1 each  upstream bubble flags.
- D_ACK  in  1  memory acknowledge (read data valid for loads).
- D_RDATA  in  REG_W  load data, valid while D_ACK=1.
- D_REQ  out  1  memory request, held until ack or abort.
- D_WE  out  1  1=store, 0=load; valid while D_REQ=1.
- D_ADDR  out  REG_W  access address.
- D_WDATA  out  REG_W  store data.
- O_LOCK  out  1  registered I_LOCK.
- O_Valid  out  1  output bundle holds a real instruction.
- O_Opcode  out  OPC_W  opcode to writeback.
- O_DestRegIdx  out  4  destination index to writeback.
- O_Result  out  REG_W  D_RDATA for LDW, else ALU result.
- O_VResult  out  VREG_W  vector result to writeback.
- O_MemStall  out  1  freeze upstream stages.
- O_MemError  out  1  sticky: a timeout occurred.

## Operation
- States: IDLE, WAIT.
- IDLE, accepting when I_LOCK=1, I_FetchStall=0, I_DepStall=0:
  - Non-memory opcode: capture opcode, index, ALU/vector results; O_Valid<=1.
  - LDW/STW: D_REQ<=1, D_WE<=(STW), D_ADDR<=I_ALUOut, D_WDATA<=I_DestValue; latch opcode and index; O_Valid<=0; O_MemStall<=1; counter<=0; go to WAIT.
- IDLE, not accepting (stall flag set or I_LOCK=0): O_Valid<=0, no memory access, outputs other than O_Valid hold.
- WAIT: inputs are ignored (upstream is frozen by O_MemStall). On each edge:
  - D_ACK=1: D_REQ<=0; O_MemStall<=0; O_Valid<=1; O_Result<=D_RDATA for LDW, or the address for STW; go to IDLE.
  - D_ACK=0 and counter=TIMEOUT-1: D_REQ<=0; O_MemStall<=0; O_MemError<=1; O_Valid<=0 (aborted instruction dropped); go to IDLE.
  - Otherwise: counter increments.
- D_ADDR, D_WE, D_WDATA are stable for the whole time D_REQ=1.
- D_ACK seen while in IDLE (a late ack after abort) is ignored and has no effect.
- O_MemError clears only on reset.

## Timing
- Reset (async, I_RESET_N=0): state IDLE; D_REQ, D_WE, O_LOCK, O_Valid, O_MemStall, O_MemError = 0; D_ADDR, D_WDATA, O_Opcode, O_DestRegIdx, O_Result, O_VResult = 0; counter 0. Asserting reset mid-WAIT drops D_REQ immediately, with no clock edge needed.
- Non-memory op: result visible one falling edge after acceptance.
- Memory op: D_REQ rises at edge N. If ack is sampled at edge N+k (k≥1), the result appears and the stall releases at edge N+k. The stage occupies 1+k edges.
- Abort: D_REQ falls and O_MemError rises at edge N+TIMEOUT.
- A new instruction can be accepted on the edge after the stall releases; no gap beyond that.

## Test plan
- Pass-through: opcode ADD_D, I_ALUOut=0x1234, I_DestRegIdx=3, no stalls -> next edge O_Valid=1, O_Result=0x1234, O_DestRegIdx=3, D_REQ stays 0.
- Load, ack after 3 edges with D_RDATA=0xBEEF, addr 0x0040 -> D_REQ=1 and D_WE=0 with D_ADDR=0x0040 for 3 edges, O_MemStall=1 throughout; then O_Valid=1, O_Result=0xBEEF, stall released.
- Store, I_ALUOut=0x0010, I_DestValue=0x00AA, ack on first edge -> D_WE=1, D_WDATA=0x00AA for 1 edge, then O_Valid=1.
- Timeout with TIMEOUT=15 and no ack -> D_REQ drops at edge N+15, O_MemError=1 and stays set, O_Valid=0; a later ack is ignored and the next ADD passes through normally.
- Upstream bubbles: I_DepStall=1 with LDW, or I_LOCK=0 -> no D_REQ, O_Valid=0.
- Reset at edge N+2 of a pending load -> D_REQ, O_MemStall and O_Valid are 0 immediately; after release, an ADD completes in one edge.

Source files
------------

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//
// Memory-access pipeline stage. Consumes the execute-stage bundle and either
// passes it straight through to writeback (all non-memory opcodes, one edge)
// or performs an LDW/STW transaction on an external variable-latency data
// memory over a req/ack handshake. While a transaction is outstanding the
// stage raises O_MemStall to freeze the upstream pipeline. A watchdog counter
// aborts transactions the memory never acknowledges and sets a sticky error.
//
// All state advances on the FALLING edge of I_CLOCK. Reset is asynchronous and
// active-low.
//
// Parameters
//   REG_W    scalar register / memory data width
//   VREG_W   vector register width
//   OPC_W    opcode width
//   TIMEOUT  edges spent in WAIT without ack before abort (1..255)
//   OP_LDW   opcode encoding of the word load
//   OP_STW   opcode encoding of the word store
//
// Ports
//   I_CLOCK, I_RESET_N        clock (falling-edge active), async reset
//   I_LOCK                    upstream pipeline running
//   I_Opcode                  opcode from execute
//   I_ALUOut                  scalar result / effective address for LDW/STW
//   I_VALUOut                 vector result
//   I_DestRegIdx              destination register index
//   I_DestValue               store data for STW
//   I_FetchStall, I_DepStall  upstream bubble flags
//   D_ACK, D_RDATA            memory acknowledge and load data
//   D_REQ, D_WE, D_ADDR,      memory request, direction, address, store data;
//   D_WDATA                   all held stable while D_REQ=1
//   O_LOCK                    registered I_LOCK
//   O_Valid                   output bundle carries a real instruction
//   O_Opcode, O_DestRegIdx    opcode / destination index to writeback
//   O_Result                  load data for LDW, address for STW, else ALU
//   O_VResult                 vector result to writeback
//   O_MemStall                freeze upstream stages
//   O_MemError                sticky: a memory access timed out
// ---------------------------------------------------------------------------
module mem_access #(
   parameter int unsigned      REG_W   = 16,
   parameter int unsigned      VREG_W  = 64,
   parameter int unsigned      OPC_W   = 8,
   parameter int unsigned      TIMEOUT = 15,
   parameter logic [OPC_W-1:0] OP_LDW  = OPC_W'('h70),
   parameter logic [OPC_W-1:0] OP_STW  = OPC_W'('h71)
) (
   input  logic              I_CLOCK,
   input  logic              I_RESET_N,
   input  logic              I_LOCK,
   input  logic [OPC_W-1:0]  I_Opcode,
   input  logic [REG_W-1:0]  I_ALUOut,
   input  logic [VREG_W-1:0] I_VALUOut,
   input  logic [3:0]        I_DestRegIdx,
   input  logic [REG_W-1:0]  I_DestValue,
   input  logic              I_FetchStall,
   input  logic              I_DepStall,
   input  logic              D_ACK,
   input  logic [REG_W-1:0]  D_RDATA,
   output logic              D_REQ,
   output logic              D_WE,
   output logic [REG_W-1:0]  D_ADDR,
   output logic [REG_W-1:0]  D_WDATA,
   output logic              O_LOCK,
   output logic              O_Valid,
   output logic [OPC_W-1:0]  O_Opcode,
   output logic [3:0]        O_DestRegIdx,
   output logic [REG_W-1:0]  O_Result,
   output logic [VREG_W-1:0] O_VResult,
   output logic              O_MemStall,
   output logic              O_MemError
);

   // Watchdog counter is wide enough for the largest legal TIMEOUT (255).
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   state_e              state_q,   state_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic                req_q,     req_d;
   logic                we_q,      we_d;
   logic [REG_W-1:0]    addr_q,    addr_d;
   logic [REG_W-1:0]    wdata_q,   wdata_d;
   logic                lock_q,    lock_d;
   logic                valid_q,   valid_d;
   logic [OPC_W-1:0]    opcode_q,  opcode_d;
   logic [3:0]          idx_q,     idx_d;
   logic [REG_W-1:0]    result_q,  result_d;
   logic [VREG_W-1:0]   vresult_q, vresult_d;
   logic                stall_q,   stall_d;
   logic                error_q,   error_d;

   // ------------------------------------------------------------------------
   // Decoded inputs
   // ------------------------------------------------------------------------
   logic accept;     // upstream presents a real instruction this edge
   logic is_mem;     // presented opcode needs the data memory
   logic is_store;
   logic timeout;    // last WAIT edge the watchdog allows

   assign accept   = I_LOCK && !I_FetchStall && !I_DepStall;
   assign is_store = (I_Opcode == OP_STW);
   assign is_mem   = (I_Opcode == OP_LDW) || is_store;
   assign timeout  = (cnt_q == CNT_LAST);

   // ------------------------------------------------------------------------
   // Process 1: state register (falling edge, async active-low reset)
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         lock_q    <= 1'b0;
         valid_q   <= 1'b0;
         opcode_q  <= '0;
         idx_q     <= '0;
         result_q  <= '0;
         vresult_q <= '0;
         stall_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         lock_q    <= lock_d;
         valid_q   <= valid_d;
         opcode_q  <= opcode_d;
         idx_q     <= idx_d;
         result_q  <= result_d;
         vresult_q <= vresult_d;
         stall_q   <= stall_d;
         error_q   <= error_d;
      end
   end

   // ------------------------------------------------------------------------
   // Process 2: next-state logic
   // ------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && is_mem) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (D_ACK || timeout) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Process 3: next values of the registered outputs and datapath
   // ------------------------------------------------------------------------
   // Everything holds unless a branch says otherwise; only O_LOCK follows its
   // input on every edge.
   always_comb begin
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      lock_d    = I_LOCK;
      valid_d   = valid_q;
      opcode_d  = opcode_q;
      idx_d     = idx_q;
      result_d  = result_q;
      vresult_d = vresult_q;
      stall_d   = stall_q;
      error_d   = error_q;

      case (state_q)
         ST_IDLE: begin
            // A bubble (or a late ack left over from an abort) produces no
            // output; only O_Valid drops.
            valid_d = 1'b0;
            if (accept) begin
               opcode_d = I_Opcode;
               idx_d    = I_DestRegIdx;
               if (is_mem) begin
                  // Address, direction and store data are captured once here
                  // and stay frozen for the whole request.
                  req_d   = 1'b1;
                  we_d    = is_store;
                  addr_d  = I_ALUOut;
                  wdata_d = I_DestValue;
                  stall_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  result_d  = I_ALUOut;
                  vresult_d = I_VALUOut;
                  valid_d   = 1'b1;
               end
            end
         end

         ST_WAIT: begin
            // Upstream inputs are not looked at here; the pipeline ahead is
            // frozen by O_MemStall.
            if (D_ACK) begin
               req_d    = 1'b0;
               stall_d  = 1'b0;
               valid_d  = 1'b1;
               // A store reports its address as the result.
               result_d = (opcode_q == OP_LDW) ? D_RDATA : addr_q;
            end else if (timeout) begin
               // Abort: the instruction is dropped and the error latches
               // until reset.
               req_d   = 1'b0;
               stall_d = 1'b0;
               valid_d = 1'b0;
               error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign D_REQ        = req_q;
   assign D_WE         = we_q;
   assign D_ADDR       = addr_q;
   assign D_WDATA      = wdata_q;
   assign O_LOCK       = lock_q;
   assign O_Valid      = valid_q;
   assign O_Opcode     = opcode_q;
   assign O_DestRegIdx = idx_q;
   assign O_Result     = result_q;
   assign O_VResult    = vresult_q;
   assign O_MemStall   = stall_q;
   assign O_MemError   = error_q;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
//
// Directed bench for mem_access. The DUT updates on the falling clock edge;
// the bench drives inputs and samples outputs on the rising edge. Every
// instruction expected to reach writeback is pushed into a scoreboard queue
// when it is issued; an independent monitor pops and compares whenever the
// DUT presents O_Valid=1. Handshake, stall and error signals are checked
// directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_mem_access;

   localparam logic [7:0] OP_ADD_D = 8'h01;
   localparam logic [7:0] OP_LDW   = 8'h70;
   localparam logic [7:0] OP_STW   = 8'h71;

   logic        I_CLOCK;
   logic        I_RESET_N;
   logic        I_LOCK;
   logic [7:0]  I_Opcode;
   logic [15:0] I_ALUOut;
   logic [63:0] I_VALUOut;
   logic [3:0]  I_DestRegIdx;
   logic [15:0] I_DestValue;
   logic        I_FetchStall;
   logic        I_DepStall;
   logic        D_ACK;
   logic [15:0] D_RDATA;
   logic        D_REQ;
   logic        D_WE;
   logic [15:0] D_ADDR;
   logic [15:0] D_WDATA;
   logic        O_LOCK;
   logic        O_Valid;
   logic [7:0]  O_Opcode;
   logic [3:0]  O_DestRegIdx;
   logic [15:0] O_Result;
   logic [63:0] O_VResult;
   logic        O_MemStall;
   logic        O_MemError;

   mem_access #(
      .REG_W   (16),
      .VREG_W  (64),
      .OPC_W   (8),
      .TIMEOUT (15),
      .OP_LDW  (OP_LDW),
      .OP_STW  (OP_STW)
   ) dut (
      .I_CLOCK      (I_CLOCK),
      .I_RESET_N    (I_RESET_N),
      .I_LOCK       (I_LOCK),
      .I_Opcode     (I_Opcode),
      .I_ALUOut     (I_ALUOut),
      .I_VALUOut    (I_VALUOut),
      .I_DestRegIdx (I_DestRegIdx),
      .I_DestValue  (I_DestValue),
      .I_FetchStall (I_FetchStall),
      .I_DepStall   (I_DepStall),
      .D_ACK        (D_ACK),
      .D_RDATA      (D_RDATA),
      .D_REQ        (D_REQ),
      .D_WE         (D_WE),
      .D_ADDR       (D_ADDR),
      .D_WDATA      (D_WDATA),
      .O_LOCK       (O_LOCK),
      .O_Valid      (O_Valid),
      .O_Opcode     (O_Opcode),
      .O_DestRegIdx (O_DestRegIdx),
      .O_Result     (O_Result),
      .O_VResult    (O_VResult),
      .O_MemStall   (O_MemStall),
      .O_MemError   (O_MemError)
   );

   initial begin
      I_CLOCK = 1'b0;
      forever #5 I_CLOCK = ~I_CLOCK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, expected finish before 100000 ns");
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   // Scoreboard and checking
   // ------------------------------------------------------------------------
   typedef struct {
      logic [7:0]  opc;
      logic [3:0]  idx;
      logic [15:0] res;
      logic [63:0] vres;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] last_v   = '0;   // O_VResult only changes on pass-through ops

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge I_CLOCK) begin
      if (I_RESET_N === 1'b1 && O_Valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got O_Valid=1 opcode %0h result %0h, expected no output",
                     O_Opcode, O_Result);
         end else begin
            mon_e = sb.pop_front();
            check("sb_opcode",  64'(O_Opcode),     64'(mon_e.opc));
            check("sb_idx",     64'(O_DestRegIdx), 64'(mon_e.idx));
            check("sb_result",  64'(O_Result),     64'(mon_e.res));
            check("sb_vresult", O_VResult,         mon_e.vres);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge I_CLOCK);
   endtask

   task automatic bubble();
      I_LOCK       = 1'b1;
      I_FetchStall = 1'b1;
      I_DepStall   = 1'b0;
      I_Opcode     = OP_ADD_D;
   endtask

   task automatic issue(input logic [7:0] opc, input logic [15:0] alu,
                        input logic [63:0] v, input logic [3:0] idx,
                        input logic [15:0] dv);
      I_LOCK       = 1'b1;
      I_FetchStall = 1'b0;
      I_DepStall   = 1'b0;
      I_Opcode     = opc;
      I_ALUOut     = alu;
      I_VALUOut    = v;
      I_DestRegIdx = idx;
      I_DestValue  = dv;
   endtask

   // Pass-through op: expected result known at issue time.
   task automatic issue_alu(input logic [15:0] alu, input logic [63:0] v,
                            input logic [3:0] idx);
      issue(OP_ADD_D, alu, v, idx, 16'h0);
      sb.push_back('{opc: OP_ADD_D, idx: idx, res: alu, vres: v});
      last_v = v;
   endtask

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      I_RESET_N    = 1'b0;
      I_LOCK       = 1'b0;
      I_Opcode     = '0;
      I_ALUOut     = '0;
      I_VALUOut    = '0;
      I_DestRegIdx = '0;
      I_DestValue  = '0;
      I_FetchStall = 1'b0;
      I_DepStall   = 1'b0;
      D_ACK        = 1'b0;
      D_RDATA      = '0;

      // Reset state
      step();
      check("rst_req",    64'(D_REQ),        64'd0);
      check("rst_we",     64'(D_WE),         64'd0);
      check("rst_addr",   64'(D_ADDR),       64'd0);
      check("rst_wdata",  64'(D_WDATA),      64'd0);
      check("rst_lock",   64'(O_LOCK),       64'd0);
      check("rst_valid",  64'(O_Valid),      64'd0);
      check("rst_opcode", 64'(O_Opcode),     64'd0);
      check("rst_idx",    64'(O_DestRegIdx), 64'd0);
      check("rst_result", 64'(O_Result),     64'd0);
      check("rst_vres",   O_VResult,         64'd0);
      check("rst_stall",  64'(O_MemStall),   64'd0);
      check("rst_error",  64'(O_MemError),   64'd0);
      I_RESET_N = 1'b1;
      bubble();
      step();
      check("lock_follows", 64'(O_LOCK),  64'd1);
      check("bubble_valid", 64'(O_Valid), 64'd0);

      // Pass-through ADD
      issue_alu(16'h1234, 64'h1111_2222_3333_4444, 4'd3);
      step();
      bubble();
      check("alu_no_req",   64'(D_REQ),      64'd0);
      check("alu_no_stall", 64'(O_MemStall), 64'd0);

      // Load, ack sampled on the third edge after the request edge
      issue(OP_LDW, 16'h0040, 64'hDEAD_DEAD_DEAD_DEAD, 4'd5, 16'h0);
      sb.push_back('{opc: OP_LDW, idx: 4'd5, res: 16'hBEEF, vres: last_v});
      for (int i = 1; i <= 3; i++) begin
         step();
         check("ld_req",   64'(D_REQ),      64'd1);
         check("ld_we",    64'(D_WE),       64'd0);
         check("ld_addr",  64'(D_ADDR),     64'h0040);
         check("ld_stall", 64'(O_MemStall), 64'd1);
         // Upstream garbage while frozen must be ignored.
         if (i == 1) issue(OP_ADD_D, 16'h9999, 64'h9999, 4'd9, 16'h9999);
         if (i == 3) begin
            D_ACK   = 1'b1;
            D_RDATA = 16'hBEEF;
         end
      end
      step();
      D_ACK = 1'b0;
      bubble();
      check("ld_req_drop",  64'(D_REQ),      64'd0);
      check("ld_stall_rel", 64'(O_MemStall), 64'd0);

      // Store, ack on the first edge; next ADD issued right after release
      issue(OP_STW, 16'h0010, 64'h0, 4'd2, 16'h00AA);
      sb.push_back('{opc: OP_STW, idx: 4'd2, res: 16'h0010, vres: last_v});
      step();
      check("st_req",   64'(D_REQ),      64'd1);
      check("st_we",    64'(D_WE),       64'd1);
      check("st_addr",  64'(D_ADDR),     64'h0010);
      check("st_wdata", 64'(D_WDATA),    64'h00AA);
      check("st_stall", 64'(O_MemStall), 64'd1);
      D_ACK   = 1'b1;
      D_RDATA = 16'h7777;
      step();
      D_ACK = 1'b0;
      check("st_req_drop",  64'(D_REQ),      64'd0);
      check("st_stall_rel", 64'(O_MemStall), 64'd0);
      issue_alu(16'h5678, 64'hAAAA_BBBB_CCCC_DDDD, 4'd7);
      step();
      bubble();

      // Timeout: no ack for TIMEOUT=15 edges
      issue(OP_LDW, 16'h0080, 64'h0, 4'd9, 16'h0);
      for (int i = 1; i <= 15; i++) begin
         step();
         if (i == 1) bubble();
         check("to_req_held", 64'(D_REQ),      64'd1);
         check("to_no_error", 64'(O_MemError), 64'd0);
      end
      step();
      check("to_req_drop",  64'(D_REQ),      64'd0);
      check("to_error",     64'(O_MemError), 64'd1);
      check("to_stall_rel", 64'(O_MemStall), 64'd0);
      check("to_valid",     64'(O_Valid),    64'd0);
      D_ACK   = 1'b1;       // late ack after the abort
      D_RDATA = 16'hDEAD;
      step();
      check("late_ack_req",   64'(D_REQ),      64'd0);
      check("late_ack_valid", 64'(O_Valid),    64'd0);
      check("late_ack_err",   64'(O_MemError), 64'd1);
      D_ACK = 1'b0;
      issue_alu(16'h0ABC, 64'h0123_4567_89AB_CDEF, 4'd1);
      step();
      bubble();
      check("err_sticky", 64'(O_MemError), 64'd1);

      // Upstream bubbles
      I_LOCK       = 1'b1;
      I_FetchStall = 1'b0;
      I_DepStall   = 1'b1;
      I_Opcode     = OP_LDW;
      I_ALUOut     = 16'h0100;
      step();
      check("dep_no_req",   64'(D_REQ),      64'd0);
      check("dep_valid",    64'(O_Valid),    64'd0);
      check("dep_no_stall", 64'(O_MemStall), 64'd0);
      I_DepStall = 1'b0;
      I_LOCK     = 1'b0;
      I_Opcode   = OP_ADD_D;
      step();
      check("unlock_no_req", 64'(D_REQ),   64'd0);
      check("unlock_valid",  64'(O_Valid), 64'd0);
      check("unlock_lock",   64'(O_LOCK),  64'd0);
      bubble();
      step();

      // Reset in the middle of a pending load
      issue(OP_LDW, 16'h0020, 64'h0, 4'd6, 16'h0);
      step();
      bubble();
      step();
      check("rw_req", 64'(D_REQ), 64'd1);
      #2 I_RESET_N = 1'b0;
      #1;
      check("rw_req_async",   64'(D_REQ),      64'd0);
      check("rw_stall_async", 64'(O_MemStall), 64'd0);
      check("rw_valid_async", 64'(O_Valid),    64'd0);
      check("rw_error_clear", 64'(O_MemError), 64'd0);
      step();
      I_RESET_N = 1'b1;
      issue_alu(16'h0F0F, 64'h5555_6666_7777_8888, 4'd4);
      step();
      bubble();
      check("post_rst_no_req", 64'(D_REQ), 64'd0);
      step();
      step();
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
